// File: rtl/sha3_scan_pkg.sv
// Shared definitions for the SHA-3 scan dispatcher.
//   scan_state_t  : dispatcher FSM states
//   scan_result_t : one found-nonce record buffered toward the host
//   SLICE_DEFAULT : default number of nonces handed to the scanner per request
package sha3_scan_pkg;

   localparam int SLICE_DEFAULT = 256;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DISPATCH = 2'd1,
      DRAIN    = 2'd2,
      DONE     = 2'd3
   } scan_state_t;

   typedef struct packed {
      logic [31:0] nonce;
      logic [63:0] hash;
      logic [7:0]  job_id;
   } scan_result_t;

endpackage

// File: rtl/sha3_result_fifo.sv
// Synchronous FIFO holding found-nonce records until the host takes them.
//   clk, rst             : clock, synchronous active-high reset (clears pointers)
//   push, push_data      : write request; ignored when full unless a pop happens
//                          in the same cycle
//   pop, pop_data        : read request; pop_data shows the head entry whenever
//                          the FIFO is non-empty (show-ahead)
//   full, empty          : occupancy flags
// DEPTH must be a power of two, 2 or larger.
module sha3_result_fifo
   import sha3_scan_pkg::*;
#(
   parameter int DEPTH = 8
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  scan_result_t push_data,
   input  logic         pop,
   output scan_result_t pop_data,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   scan_result_t mem [DEPTH];

   // One extra pointer bit distinguishes full from empty when indices match.
   logic [AW:0] wr_ptr_reg;
   logic [AW:0] rd_ptr_reg;
   logic        do_push;
   logic        do_pop;

   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                  (wr_ptr_reg[AW] != rd_ptr_reg[AW]);

   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so a push at full still lands.
   assign do_push = push && (!full || do_pop);

   // The head is read combinationally so out_valid and its data appear
   // together one cycle after the first push.
   assign pop_data = mem[rd_ptr_reg[AW-1:0]];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg[AW-1:0]] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + {{AW{1'b0}}, 1'b1};
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + {{AW{1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: rtl/sha3_scan_dispatcher.sv
// Splits a mining job (nonce range + threshold) into fixed-size scan requests,
// limits how many requests are in flight, and buffers found nonces for the host.
//   clk, rst                      : clock, synchronous active-high reset
//   job_*                         : job handshake and fields from the host
//   abort                         : cancel the job currently being dispatched
//   req_*                         : scan request handshake toward the scanner
//   scan_done                     : pulse, scanner finished one request
//   res_valid, res_nonce, res_hash: found nonce from scanner (no back-pressure)
//   out_*                         : found-result stream toward the host
//   job_done                      : one-cycle pulse when a job has fully drained
//   busy                          : high whenever a job is being processed
//   dropped                       : saturating count of results lost to a full buffer
module sha3_scan_dispatcher
   import sha3_scan_pkg::*;
#(
   parameter int SLICE           = SLICE_DEFAULT,
   parameter int FIFO_DEPTH      = 8,
   parameter int MAX_OUTSTANDING = 4
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        job_valid,
   output logic        job_ready,
   input  logic [31:0] job_nonce_start,
   input  logic [31:0] job_nonce_count,
   input  logic [63:0] job_threshold,
   input  logic [7:0]  job_id,
   input  logic        abort,
   output logic        req_valid,
   input  logic        req_ready,
   output logic [31:0] req_nonce_start,
   output logic [16:0] req_nonce_count,
   output logic [63:0] req_threshold,
   input  logic        scan_done,
   input  logic        res_valid,
   input  logic [31:0] res_nonce,
   input  logic [63:0] res_hash,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_nonce,
   output logic [63:0] out_hash,
   output logic [7:0]  out_job_id,
   output logic        job_done,
   output logic        busy,
   output logic [15:0] dropped
);

   localparam int          OW        = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [16:0] SLICE_CNT = 17'(SLICE);

   scan_state_t   state_reg, state_next;
   logic [31:0]   next_nonce_reg, next_nonce_next;
   logic [31:0]   remaining_reg, remaining_next;
   logic [OW-1:0] outstanding_reg, outstanding_next;
   logic [63:0]   threshold_reg, threshold_next;
   logic [7:0]    job_id_reg, job_id_next;
   logic [15:0]   dropped_reg;
   logic          job_done_reg;

   logic          req_fire;
   logic          scan_dec;
   logic [16:0]   slice_count;
   logic          fifo_full;
   logic          fifo_empty;
   logic          fifo_pop;
   logic          res_lost;
   scan_result_t  push_data;
   scan_result_t  pop_data;

   // Last request of a job carries whatever is left below one slice.
   assign slice_count = (remaining_reg < {15'd0, SLICE_CNT}) ? remaining_reg[16:0]
                                                             : SLICE_CNT;

   // Request fields come straight from registers that only move on a
   // handshake, so they hold steady while the scanner back-pressures.
   assign req_nonce_start = next_nonce_reg;
   assign req_nonce_count = slice_count;
   assign req_threshold   = threshold_reg;
   assign req_fire        = req_valid && req_ready;

   // A completion with nothing in flight is spurious and must not underflow.
   assign scan_dec = scan_done && (outstanding_reg != '0);

   always_comb begin
      state_next      = state_reg;
      next_nonce_next = next_nonce_reg;
      remaining_next  = remaining_reg;
      threshold_next  = threshold_reg;
      job_id_next     = job_id_reg;
      job_ready       = 1'b0;
      req_valid       = 1'b0;

      case (state_reg)
         IDLE: begin
            job_ready = !rst;
            if (job_valid && !rst) begin
               next_nonce_next = job_nonce_start;
               remaining_next  = job_nonce_count;
               threshold_next  = job_threshold;
               job_id_next     = job_id;
               state_next      = (job_nonce_count == 32'd0) ? DONE : DISPATCH;
            end
         end
         DISPATCH: begin
            req_valid = (remaining_reg != 32'd0) &&
                        (outstanding_reg < OW'(MAX_OUTSTANDING));
            if (req_valid && req_ready) begin
               next_nonce_next = next_nonce_reg + {15'd0, slice_count};
               remaining_next  = remaining_reg - {15'd0, slice_count};
            end
            // A request accepted in the abort cycle is still in flight and is
            // counted; only the not-yet-issued range is thrown away.
            if (abort) begin
               remaining_next = 32'd0;
               state_next     = DRAIN;
            end else if (remaining_reg == 32'd0) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            // Hold off completion while the scanner is still reporting results.
            if ((outstanding_reg == '0) && !res_valid) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_comb begin
      outstanding_next = outstanding_reg;
      case ({req_fire, scan_dec})
         2'b10:   outstanding_next = outstanding_reg + OW'(1);
         2'b01:   outstanding_next = outstanding_reg - OW'(1);
         default: outstanding_next = outstanding_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= IDLE;
         next_nonce_reg  <= '0;
         remaining_reg   <= '0;
         outstanding_reg <= '0;
         threshold_reg   <= '0;
         job_id_reg      <= '0;
         job_done_reg    <= 1'b0;
      end else begin
         state_reg       <= state_next;
         next_nonce_reg  <= next_nonce_next;
         remaining_reg   <= remaining_next;
         outstanding_reg <= outstanding_next;
         threshold_reg   <= threshold_next;
         job_id_reg      <= job_id_next;
         job_done_reg    <= (state_reg == DONE);
      end
   end

   // Results are tagged with the job that was latched when they arrived.
   assign push_data = '{nonce: res_nonce, hash: res_hash, job_id: job_id_reg};
   assign fifo_pop  = out_ready && !fifo_empty;
   assign res_lost  = res_valid && fifo_full && !fifo_pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         dropped_reg <= '0;
      end else if (res_lost && (dropped_reg != 16'hFFFF)) begin
         dropped_reg <= dropped_reg + 16'd1;
      end
   end

   sha3_result_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_result_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (res_valid),
      .push_data (push_data),
      .pop       (out_ready),
      .pop_data  (pop_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign out_valid  = !fifo_empty;
   assign out_nonce  = pop_data.nonce;
   assign out_hash   = pop_data.hash;
   assign out_job_id = pop_data.job_id;

   assign job_done = job_done_reg;
   assign busy     = (state_reg != IDLE);
   assign dropped  = dropped_reg;

endmodule

// File: tb/tb_sha3_scan_dispatcher.sv
// Self-checking bench for sha3_scan_dispatcher: table of jobs, hand-written
// corner sequences, then randomized jobs with random back-pressure, scanner
// latency and result traffic, all checked against a queue-based reference.
module tb_sha3_scan_dispatcher;

   localparam int SLICE = 256;
   localparam int DEPTH = 8;
   localparam int MAXO  = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        job_valid = 1'b0;
   logic        job_ready;
   logic [31:0] job_nonce_start = '0;
   logic [31:0] job_nonce_count = '0;
   logic [63:0] job_threshold = '0;
   logic [7:0]  job_id = '0;
   logic        abort = 1'b0;
   logic        req_valid;
   logic        req_ready = 1'b0;
   logic [31:0] req_nonce_start;
   logic [16:0] req_nonce_count;
   logic [63:0] req_threshold;
   logic        scan_done = 1'b0;
   logic        res_valid = 1'b0;
   logic [31:0] res_nonce = '0;
   logic [63:0] res_hash = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_nonce;
   logic [63:0] out_hash;
   logic [7:0]  out_job_id;
   logic        job_done;
   logic        busy;
   logic [15:0] dropped;

   always #5 clk = ~clk;

   sha3_scan_dispatcher #(
      .SLICE           (SLICE),
      .FIFO_DEPTH      (DEPTH),
      .MAX_OUTSTANDING (MAXO)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .job_valid       (job_valid),
      .job_ready       (job_ready),
      .job_nonce_start (job_nonce_start),
      .job_nonce_count (job_nonce_count),
      .job_threshold   (job_threshold),
      .job_id          (job_id),
      .abort           (abort),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_nonce_start (req_nonce_start),
      .req_nonce_count (req_nonce_count),
      .req_threshold   (req_threshold),
      .scan_done       (scan_done),
      .res_valid       (res_valid),
      .res_nonce       (res_nonce),
      .res_hash        (res_hash),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_nonce       (out_nonce),
      .out_hash        (out_hash),
      .out_job_id      (out_job_id),
      .job_done        (job_done),
      .busy            (busy),
      .dropped         (dropped)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model state (written by the monitor) -------
   typedef struct {
      logic [31:0] n;
      logic [63:0] h;
      logic [7:0]  id;
   } res_t;

   res_t        mq[$];
   logic [31:0] rq_start[$];
   int          rq_count[$];
   int          mdrop = 0;
   int          outst_m = 0;
   int          hs_count = 0;
   int          done_cnt = 0;
   int          pops = 0;
   logic [7:0]  cur_id = '0;
   logic [63:0] cur_thr = '0;

   // ---------------- stimulus control (written by the main process) -------
   int issued = 0;
   int grant = 1 << 30;
   int scan_pct = 100;
   int rdy_mode = 1;
   bit rnd_io = 1'b0;

   // Observes every cycle away from the active edge; inputs change #1 after
   // the rising edge, so what is seen here is what the DUT samples next edge.
   always @(negedge clk) begin
      if (rst) begin
         mq.delete();
         mdrop   = 0;
         outst_m = 0;
         cur_id  = '0;
         cur_thr = '0;
      end else begin
         check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
         check("dropped", 64'(dropped), 64'(mdrop));
         if (outst_m >= MAXO) check("req_valid_stall", 64'(req_valid), 64'd0);
         if (job_done) begin
            done_cnt++;
            check("done_outstanding", 64'(outst_m), 64'd0);
            check("done_busy", 64'(busy), 64'd0);
         end
         if (req_valid && req_ready) begin
            rq_start.push_back(req_nonce_start);
            rq_count.push_back(int'(req_nonce_count));
            hs_count++;
            check("req_threshold", req_threshold, cur_thr);
         end
         if (out_ready && mq.size() != 0) begin
            check("out_nonce", 64'(out_nonce), 64'(mq[0].n));
            check("out_hash", out_hash, mq[0].h);
            check("out_job_id", 64'(out_job_id), 64'(mq[0].id));
            void'(mq.pop_front());
            pops++;
         end
         if (res_valid) begin
            if (mq.size() < DEPTH) mq.push_back('{n: res_nonce, h: res_hash, id: cur_id});
            else if (mdrop < 65535) mdrop++;
         end
         if (req_valid && req_ready) outst_m++;
         if (scan_done && outst_m > 0 && !(req_valid && req_ready)) outst_m--;
         else if (scan_done && outst_m > 1 && (req_valid && req_ready)) outst_m--;
         if (job_valid && job_ready) begin
            cur_id  = job_id;
            cur_thr = job_threshold;
         end
      end
   end

   // One clock: the scanner completes accepted requests (subject to grant and
   // scan_pct), req_ready follows rdy_mode, and optional random result traffic.
   task automatic step();
      @(posedge clk);
      #1;
      scan_done = 1'b0;
      if (hs_count > issued && issued < grant && $urandom_range(0, 99) < scan_pct) begin
         scan_done = 1'b1;
         issued++;
      end
      if (rdy_mode == 2)      req_ready = 1'($urandom_range(0, 1));
      else if (rdy_mode == 1) req_ready = 1'b1;
      else                    req_ready = 1'b0;
      if (rnd_io) begin
         res_valid = ($urandom_range(0, 3) == 0);
         res_nonce = $urandom;
         res_hash  = {$urandom, $urandom};
         out_ready = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_ready = 1'b0;
      rdy_mode = 0;
      step();
      step();
      check("rst_job_ready", 64'(job_ready), 64'd0);
      check("rst_req_valid", 64'(req_valid), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_job_done", 64'(job_done), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_dropped", 64'(dropped), 64'd0);
      rst = 1'b0;
      issued = hs_count;
      rdy_mode = 1;
      step();
      check("post_rst_job_ready", 64'(job_ready), 64'd1);
   endtask

   task automatic start_job(input logic [31:0] s, input logic [31:0] c);
      int n = 0;
      job_valid       = 1'b1;
      job_nonce_start = s;
      job_nonce_count = c;
      job_threshold   = {$urandom, $urandom};
      job_id          = 8'($urandom);
      while (!job_ready && n < 200) begin
         step();
         n++;
      end
      check("job_ready", 64'(job_ready), 64'd1);
      step();
      job_valid = 1'b0;
   endtask

   task automatic wait_done(input int dbase, input int bound);
      int n = 0;
      while (done_cnt == dbase && n < bound) begin
         step();
         n++;
      end
      check("job_done_seen", 64'(done_cnt - dbase), 64'd1);
   endtask

   // Expected request list: consecutive SLICE-sized chunks of the range,
   // last one short, start addresses wrapping modulo 2^32.
   task automatic check_reqs(input int base, input logic [31:0] s, input logic [31:0] c);
      longint      rem = longint'(c);
      logic [31:0] ns = s;
      int          k = 0;
      int          sc;
      while (rem > 0) begin
         sc = (rem < SLICE) ? int'(rem) : SLICE;
         if (base + k < rq_start.size()) begin
            check("req_start", 64'(rq_start[base + k]), 64'(ns));
            check("req_count", 64'(rq_count[base + k]), 64'(sc));
         end
         ns  = ns + 32'(sc);
         rem = rem - longint'(sc);
         k++;
      end
      check("req_total", 64'(rq_start.size() - base), 64'(k));
   endtask

   task automatic run_job(input logic [31:0] s, input logic [31:0] c, input int bound);
      int base  = rq_start.size();
      int dbase = done_cnt;
      start_job(s, c);
      wait_done(dbase, bound);
      check_reqs(base, s, c);
      $display("job start=%08h count=%0d requests=%0d", s, c, rq_start.size() - base);
   endtask

   typedef struct {
      logic [31:0] start;
      logic [31:0] count;
      int          n_req;
      logic [31:0] last_start;
      int          last_count;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int base;
      int dbase;
      int pbase;
      logic [31:0] s;
      logic [31:0] c;

      vecs[0] = '{32'h0000_0000, 32'd1000, 4, 32'd768,        232};
      vecs[1] = '{32'hFFFF_FF80, 32'd256,  1, 32'hFFFF_FF80,  256};
      vecs[2] = '{32'h0000_1234, 32'd0,    0, 32'h0000_0000,  0};
      vecs[3] = '{32'd10,        32'd257,  2, 32'd266,        1};
      vecs[4] = '{32'hFFFF_FFFF, 32'd300,  2, 32'h0000_00FF,  44};
      vecs[5] = '{32'd5,         32'd16,   1, 32'd5,          16};

      do_reset();
      out_ready = 1'b1;

      // Table of jobs with an always-ready, prompt scanner.
      for (int i = 0; i < 6; i++) begin
         base = rq_start.size();
         run_job(vecs[i].start, vecs[i].count, 2000);
         check("tbl_n_req", 64'(rq_start.size() - base), 64'(vecs[i].n_req));
         if (vecs[i].n_req > 0 && rq_start.size() >= base + vecs[i].n_req) begin
            check("tbl_last_start", 64'(rq_start[base + vecs[i].n_req - 1]), 64'(vecs[i].last_start));
            check("tbl_last_count", 64'(rq_count[base + vecs[i].n_req - 1]), 64'(vecs[i].last_count));
         end
      end

      // Overflow: host stalled, 10 results into an 8-deep buffer.
      out_ready = 1'b0;
      pbase = pops;
      check("fifo_empty_before", 64'(out_valid), 64'd0);
      for (int i = 0; i < 10; i++) begin
         res_valid = 1'b1;
         res_nonce = 32'h1000 + 32'(i);
         res_hash  = {$urandom, $urandom};
         step();
         if (i == 0) check("first_word_latency", 64'(out_valid), 64'd1);
      end
      res_valid = 1'b0;
      step();
      check("overflow_dropped", 64'(dropped), 64'd2);
      $display("overflow pushed=10 dropped=%0d", dropped);
      out_ready = 1'b1;
      repeat (12) step();
      check("overflow_pops", 64'(pops - pbase), 64'd8);
      check("overflow_drained", 64'(out_valid), 64'd0);

      // Zero-length job: done pulse exactly two cycles after the handshake.
      base  = rq_start.size();
      start_job(32'h55, 32'd0);
      check("cnt0_c1_done", 64'(job_done), 64'd0);
      check("cnt0_c1_busy", 64'(busy), 64'd1);
      step();
      check("cnt0_c2_done", 64'(job_done), 64'd1);
      check("cnt0_c2_busy", 64'(busy), 64'd0);
      step();
      check("cnt0_c3_done", 64'(job_done), 64'd0);
      check("cnt0_no_req", 64'(rq_start.size() - base), 64'd0);
      $display("job start=00000055 count=0 requests=%0d", rq_start.size() - base);

      // Scanner withholds completions: dispatch stalls at MAXO in flight.
      grant = issued;
      base  = rq_start.size();
      dbase = done_cnt;
      start_job(32'd0, 32'd4096);
      repeat (20) step();
      check("stall_reqs", 64'(rq_start.size() - base), 64'(MAXO));
      check("stall_req_valid", 64'(req_valid), 64'd0);
      for (int i = 0; i < 3; i++) begin
         grant = issued + 1;
         repeat (10) step();
         check("release_reqs", 64'(rq_start.size() - base), 64'(MAXO + 1 + i));
      end
      grant = 1 << 30;
      wait_done(dbase, 3000);
      check_reqs(base, 32'd0, 32'd4096);
      $display("job start=00000000 count=4096 requests=%0d (throttled)", rq_start.size() - base);

      // Abort after the second request.
      grant = issued;
      base  = rq_start.size();
      dbase = done_cnt;
      start_job(32'd0, 32'd1000);
      for (int n = 0; n < 100 && rq_start.size() - base < 2; n++) step();
      rdy_mode  = 0;
      req_ready = 1'b0;
      abort     = 1'b1;
      step();
      abort = 1'b0;
      check("abort_req_valid", 64'(req_valid), 64'd0);
      rdy_mode  = 1;
      req_ready = 1'b1;
      repeat (10) step();
      check("abort_reqs", 64'(rq_start.size() - base), 64'd2);
      check("abort_busy_drain", 64'(busy), 64'd1);
      if (rq_start.size() - base >= 2) begin
         check("abort_req0_start", 64'(rq_start[base]), 64'd0);
         check("abort_req1_start", 64'(rq_start[base + 1]), 64'd256);
         check("abort_req1_count", 64'(rq_count[base + 1]), 64'd256);
      end
      grant = issued + 2;
      wait_done(dbase, 100);
      grant = 1 << 30;
      $display("job start=00000000 count=1000 requests=%0d (aborted)", rq_start.size() - base);

      // Abort while idle has no effect.
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_idle_busy", 64'(busy), 64'd0);
      check("abort_idle_ready", 64'(job_ready), 64'd1);

      // Randomized jobs with random back-pressure, latency and result traffic.
      rnd_io   = 1'b1;
      rdy_mode = 2;
      scan_pct = 35;
      for (int j = 0; j < 8; j++) begin
         if ($urandom_range(0, 3) == 0) s = 32'hFFFF_FFFF - 32'($urandom_range(0, 600));
         else                           s = $urandom;
         c = 32'($urandom_range(0, 1500));
         run_job(s, c, 20000);
      end
      rnd_io    = 1'b0;
      res_valid = 1'b0;
      out_ready = 1'b1;
      rdy_mode  = 1;
      scan_pct  = 100;
      repeat (20) step();
      check("final_drained", 64'(out_valid), 64'd0);

      // Reset in the middle of a job: job is discarded without a done pulse.
      grant = issued;
      out_ready = 1'b0;
      start_job(32'd0, 32'd4096);
      repeat (5) step();
      res_valid = 1'b1;
      res_nonce = 32'hABCD;
      step();
      res_valid = 1'b0;
      dbase = done_cnt;
      do_reset();
      grant = 1 << 30;
      repeat (10) step();
      check("rst_midjob_no_done", 64'(done_cnt - dbase), 64'd0);
      check("rst_midjob_idle", 64'(busy), 64'd0);
      $display("reset mid-job: busy=%0d out_valid=%0d", busy, out_valid);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule
